// File: rtl/maze_pkg.sv
// Shared definitions for the maze path engine: direction codes, FSM states
// and the opposite-direction helper used when backtracking.
package maze_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_WAIT,
        ST_BACKTRACK,
        ST_EMIT,
        ST_DONE,
        ST_FAIL
    } state_e;

    // Codes are laid out so that opposite pairs (0,3) and (1,2) sum to 3.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return 2'd3 - d;
    endfunction

endpackage

// File: rtl/maze_dir_stack.sv
// LIFO of 2-bit direction codes with push/pop, empty/full flags and an
// indexed read port so the finished path can be replayed oldest-first.
module maze_dir_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [1:0]    push_dir,
    input  logic          pop,
    output logic [1:0]    top_dir,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    input  logic [AW-1:0] rd_idx,
    output logic [1:0]    rd_dir
);

    logic [1:0]    mem_q [DEPTH];
    logic [1:0]    mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign top_dir = mem_q[AW'(count_q - CW'(1))];
    assign rd_dir  = mem_q[rd_idx];

    // Clear wins over push, push over pop; the FSM never requests both at once.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !full) begin
            mem_d[AW'(count_q)] = push_dir;
            count_d             = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/maze_path_engine.sv
// Depth-first maze solver on a 2^N x 2^N grid from (0,0) to the far corner,
// replaying the found path as direction codes. MAZE_PERF_EN adds a cycle counter.
module maze_path_engine
    import maze_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 2 ** (2 * N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           map_rd_en,
    output logic [2*N-1:0] map_rd_addr,
    input  logic           map_rd_data,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic           move_valid,
    input  logic           move_ready,
    output logic [1:0]     move,
    output logic [N-1:0]   X,
    output logic [N-1:0]   Y
`ifdef MAZE_PERF_EN
    ,
    output logic [15:0]    cycles
`endif
);

    localparam int CELLS = 2 ** (2 * N);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [N-1:0]   ONE    = N'(1);
    localparam logic [N-1:0]   MAX_C  = {N{1'b1}};
    localparam logic [2*N-1:0] GOAL   = {(2 * N){1'b1}};

    state_e           state_q, state_d;
    logic [N-1:0]     x_q, x_d, y_q, y_d;
    logic [1:0]       dir_q, dir_d;
    logic [CELLS-1:0] visited_q, visited_d;
    logic [CW-1:0]    emit_idx_q, emit_idx_d;

    logic             stk_clear, stk_push, stk_pop;
    logic [1:0]       stk_top, stk_rd_dir;
    logic             stk_empty, stk_full;
    logic [CW-1:0]    stk_count;

    logic [2*N-1:0]   nb_cell, back_cell;
    logic             nb_in_range, nb_open;

    function automatic logic [2*N-1:0] step_cell(input logic [N-1:0] cx,
                                                 input logic [N-1:0] cy,
                                                 input logic [1:0]   d);
        logic [N-1:0] sx;
        logic [N-1:0] sy;
        sx = cx;
        sy = cy;
        case (d)
            DIR_UP:    sy = cy - ONE;
            DIR_RIGHT: sx = cx + ONE;
            DIR_LEFT:  sx = cx - ONE;
            default:   sy = cy + ONE;
        endcase
        return {sy, sx};
    endfunction

    maze_dir_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .clear    (stk_clear),
        .push     (stk_push),
        .push_dir (dir_q),
        .pop      (stk_pop),
        .top_dir  (stk_top),
        .empty    (stk_empty),
        .full     (stk_full),
        .count    (stk_count),
        .rd_idx   (AW'(emit_idx_q)),
        .rd_dir   (stk_rd_dir)
    );

    // A neighbour is out of range whenever the step would wrap the coordinate.
    always_comb begin
        nb_cell   = step_cell(x_q, y_q, dir_q);
        back_cell = step_cell(x_q, y_q, opposite_dir(stk_top));
        case (dir_q)
            DIR_UP:    nb_in_range = (y_q != '0);
            DIR_RIGHT: nb_in_range = (x_q != MAX_C);
            DIR_LEFT:  nb_in_range = (x_q != '0);
            default:   nb_in_range = (y_q != MAX_C);
        endcase
        nb_open = nb_in_range && !visited_q[nb_cell];
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        visited_d   = visited_q;
        emit_idx_d  = emit_idx_q;
        stk_clear   = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        fail        = 1'b0;
        move_valid  = 1'b0;
        move        = 2'd0;
        map_rd_en   = 1'b0;
        map_rd_addr = {y_q, x_q};

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                done = (state_q == ST_DONE);
                fail = (state_q == ST_FAIL);
                if (start) begin
                    stk_clear    = 1'b1;
                    x_d          = '0;
                    y_d          = '0;
                    dir_d        = DIR_UP;
                    visited_d    = '0;
                    visited_d[0] = 1'b1;
                    emit_idx_d   = '0;
                    state_d      = ST_PROBE;
                end
            end

            ST_PROBE: begin
                busy = 1'b1;
                if (nb_open) begin
                    map_rd_en   = 1'b1;
                    map_rd_addr = nb_cell;
                    state_d     = ST_WAIT;
                end else if (dir_q != DIR_DOWN) begin
                    dir_d = dir_q + 2'd1;
                end else begin
                    state_d = ST_BACKTRACK;
                end
            end

            // The neighbour read last cycle is still selected by dir_q here.
            ST_WAIT: begin
                busy = 1'b1;
                if (!map_rd_data) begin
                    if (stk_full) begin
                        state_d = ST_FAIL;
                    end else begin
                        stk_push           = 1'b1;
                        {y_d, x_d}         = nb_cell;
                        visited_d[nb_cell] = 1'b1;
                        dir_d              = DIR_UP;
                        emit_idx_d         = '0;
                        state_d            = (nb_cell == GOAL) ? ST_EMIT : ST_PROBE;
                    end
                end else if (dir_q != DIR_DOWN) begin
                    dir_d   = dir_q + 2'd1;
                    state_d = ST_PROBE;
                end else begin
                    state_d = ST_BACKTRACK;
                end
            end

            ST_BACKTRACK: begin
                busy = 1'b1;
                if (stk_empty) begin
                    state_d = ST_FAIL;
                end else begin
                    stk_pop    = 1'b1;
                    {y_d, x_d} = back_cell;
                    if (stk_top != DIR_DOWN) begin
                        dir_d   = stk_top + 2'd1;
                        state_d = ST_PROBE;
                    end
                end
            end

            ST_EMIT: begin
                busy       = 1'b1;
                move_valid = 1'b1;
                move       = stk_rd_dir;
                if (move_ready) begin
                    if (emit_idx_q == stk_count - CW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        emit_idx_d = emit_idx_q + CW'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            dir_q      <= DIR_UP;
            visited_q  <= '0;
            emit_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            visited_q  <= visited_d;
            emit_idx_q <= emit_idx_d;
        end
    end

    assign X = x_q;
    assign Y = y_q;

`ifdef MAZE_PERF_EN
    logic [15:0] cycles_q, cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (start && !busy) begin
            cycles_d = '0;
        end else if (busy && (cycles_q != 16'hFFFF)) begin
            cycles_d = cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_maze_path_engine.sv
// Scoreboard bench for maze_path_engine on a 4x4 grid: expected moves are
// queued by the stimulus and popped by a monitor on each accepted transfer.
module tb_maze_path_engine;

    localparam int N     = 2;
    localparam int DEPTH = 16;
    localparam int CELLS = 16;

    logic           clk         = 1'b0;
    logic           rst         = 1'b1;
    logic           start       = 1'b0;
    logic           map_rd_en;
    logic [2*N-1:0] map_rd_addr;
    logic           map_rd_data = 1'b0;
    logic           busy, done, fail, move_valid;
    logic           move_ready  = 1'b1;
    logic [1:0]     move;
    logic [N-1:0]   X, Y;
`ifdef MAZE_PERF_EN
    logic [15:0]    cycles;
`endif

    logic       map_mem [CELLS];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [1:0] exp_q [$];
    int         rd_count    = 0;
    int         busy_count  = 0;
    bit         toggle_ready = 1'b0;
    bit         stalled_prev = 1'b0;
    logic [1:0] stall_move   = 2'd0;
    int         expected_path [12] = '{1, 1, 1, 3, 2, 2, 2, 3, 1, 1, 1, 3};

    maze_path_engine #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .map_rd_en   (map_rd_en),
        .map_rd_addr (map_rd_addr),
        .map_rd_data (map_rd_data),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move        (move),
        .X           (X),
        .Y           (Y)
`ifdef MAZE_PERF_EN
        ,
        .cycles      (cycles)
`endif
    );

    always #5 clk = ~clk;

    // Map memory answers one cycle after the strobe.
    always @(posedge clk) begin
        map_rd_data <= map_rd_en ? map_mem[map_rd_addr] : 1'b0;
    end

    always @(posedge clk) begin
        #1;
        move_ready = toggle_ready ? ~move_ready : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted move and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            if (map_rd_en) rd_count++;
            if (busy) busy_count++;
            if (move_valid) begin
                if (stalled_prev) check("move_stable", {30'd0, move}, {30'd0, stall_move});
                if (move_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_move: got %0d, expected no transfer", move);
                    end else begin
                        check("move", {30'd0, move}, {30'd0, exp_q.pop_front()});
                    end
                end
            end
            stalled_prev = move_valid && !move_ready;
            stall_move   = move;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic load_path();
        for (int i = 0; i < 12; i++) exp_q.push_back(expected_path[i][1:0]);
    endtask

    task automatic set_open_map();
        for (int i = 0; i < CELLS; i++) map_mem[i] = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n;
        n = 0;
        while (!(done || fail) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!(done || fail)) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: got no done/fail, expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_fail"}, {31'd0, fail}, 0);
        check({tag, "_move_valid"}, {31'd0, move_valid}, 0);
        check({tag, "_map_rd_en"}, {31'd0, map_rd_en}, 0);
        check({tag, "_move"}, {30'd0, move}, 0);
        check({tag, "_X"}, {30'd0, X}, 0);
        check({tag, "_Y"}, {30'd0, Y}, 0);
    endtask

    task automatic run_open_search(input string tag);
        set_open_map();
        load_path();
        busy_count = 0;
        pulse_start();
        wait_end(tag, 400);
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_fail"}, {31'd0, fail}, 0);
        check({tag, "_remaining"}, exp_q.size(), 0);
`ifdef MAZE_PERF_EN
        check({tag, "_cycles"}, {16'd0, cycles}, busy_count);
`endif
    endtask

    initial begin
        int reads;
        int n;
        set_open_map();
        #3 rst = 1'b0;
        #10;
        check_reset_outputs("reset");
        check("reset_addr", {28'd0, map_rd_addr}, 0);
        @(negedge clk);
        rst = 1'b1;

        // All-open map, ready held high.
        run_open_search("open");
        @(negedge clk);
        check("open_done_hold", {31'd0, done}, 1);

        // Walls on both exits of the start cell: two reads, then fail.
        set_open_map();
        map_mem[1] = 1'b1;
        map_mem[4] = 1'b1;
        rd_count = 0;
        pulse_start();
        wait_end("walled", 100);
        check("walled_fail", {31'd0, fail}, 1);
        check("walled_done", {31'd0, done}, 0);
        check("walled_reads", rd_count, 2);

        // Same open map with ready toggling.
        toggle_ready = 1'b1;
        run_open_search("stall");
        toggle_ready = 1'b0;

        // Reset asserted while waiting on the third map read, at cell (2,0).
        set_open_map();
        pulse_start();
        reads = 0;
        n = 0;
        while (reads < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (map_rd_en) reads++;
        end
        check("wait_reached", reads, 3);
        check("wait_X_before", {30'd0, X}, 2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        run_open_search("rerun");

        // Start held high: no restart while busy, new search right after done.
        load_path();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_end("held_a", 400);
        check("held_a_done", {31'd0, done}, 1);
        load_path();
        @(negedge clk);
        check("held_restart_busy", {31'd0, busy}, 1);
        check("held_restart_done", {31'd0, done}, 0);
        start = 1'b0;
        wait_end("held_b", 400);
        check("held_b_done", {31'd0, done}, 1);
        check("held_remaining", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
